// File: rtl/fnd_scan_controller_pkg.sv
// fnd_scan_controller_pkg: shared digit constants, FSM encoding and the double-dabble nibble adjust
package fnd_scan_controller_pkg;
  localparam int NUM_DIGITS  = 4;
  localparam int BCD_W       = 4;
  localparam int MAX_DISPLAY = 9999;
  localparam int BCD_TOTAL_W = NUM_DIGITS * BCD_W;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
  function automatic logic [BCD_TOTAL_W-1:0] bcd_adjust(input logic [BCD_TOTAL_W-1:0] b);
    logic [BCD_TOTAL_W-1:0] r;
    for (int i = 0; i < NUM_DIGITS; i++)
      r[i*BCD_W +: BCD_W] = (b[i*BCD_W +: BCD_W] >= 4'd5) ? b[i*BCD_W +: BCD_W] + 4'd3 : b[i*BCD_W +: BCD_W];
    return r;
  endfunction
endpackage

// File: rtl/fnd_scan_prescaler.sv
// fnd_scan_prescaler: free-running 0..DIV-1 counter asserting o_tick in the DIV-1 cycle
module fnd_scan_prescaler
  import fnd_scan_controller_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  output logic o_tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  if (DIV < 2) begin : g_div_check
    $error("fnd_scan_prescaler: DIV must be >= 2");
  end
  logic [CW-1:0] cnt_q, cnt_d;
  assign o_tick = cnt_q == CW'(DIV - 1);
  always_comb cnt_d = o_tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge i_clk) cnt_q <= !i_reset_n ? '0 : cnt_d;
endmodule

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: binary-to-BCD double-dabble conversion and 4-digit FND scan mux with leading-zero blanking
module fnd_scan_controller
  import fnd_scan_controller_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int VALUE_W = 14
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_load,
  output logic [1:0]         o_digitPosition,
  output logic [BCD_W-1:0]   o_bcd,
  output logic               o_blank,
  output logic               o_busy
);
  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int SR_W  = BCD_TOTAL_W + VALUE_W;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  state_e                 state_q, state_d;
  logic [SR_W-1:0]        sr_q, sr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BCD_TOTAL_W-1:0] disp_q, disp_d;
  logic [1:0]             pos_q, pos_d;
  logic                   busy_q, busy_d;
  logic                   tick;
  logic [VALUE_W-1:0]     value_sat;
  fnd_scan_prescaler #(.DIV(DIV)) u_prescaler (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .o_tick    (tick)
  );
  assign value_sat = (32'(i_value) > 32'(MAX_DISPLAY)) ? VALUE_W'(MAX_DISPLAY) : i_value;
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    pos_d   = tick ? pos_q + 2'd1 : pos_q;
    case (state_q)
      IDLE: if (i_load) begin
        state_d = SHIFT;
        sr_d    = {{BCD_TOTAL_W{1'b0}}, value_sat};
        cnt_d   = '0;
      end
      SHIFT: begin
        sr_d  = {bcd_adjust(sr_q[SR_W-1 -: BCD_TOTAL_W]), sr_q[VALUE_W-1:0]} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = DONE;
      end
      DONE: begin
        disp_d  = sr_q[SR_W-1 -: BCD_TOTAL_W];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      pos_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      pos_q   <= pos_d;
      busy_q  <= busy_d;
    end
  end
  assign o_digitPosition = pos_q;
  assign o_busy          = busy_q;
  assign o_bcd           = disp_q[{pos_q, 2'b00} +: BCD_W];
  assign o_blank         = (pos_q != 2'd0) && ((disp_q >> {pos_q, 2'b00}) == '0);
endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb_fnd_scan_controller: directed self-checking bench for the FND scan controller
module tb_fnd_scan_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] value;
  logic        load;
  logic [1:0]  o_digitPosition;
  logic [3:0]  o_bcd;
  logic        o_blank;
  logic        o_busy;
  int          checks = 0;
  int          errors = 0;
  fnd_scan_controller #(.CLK_HZ(8), .SCAN_HZ(2), .VALUE_W(14)) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_value         (value),
    .i_load          (load),
    .o_digitPosition (o_digitPosition),
    .o_bcd           (o_bcd),
    .o_blank         (o_blank),
    .o_busy          (o_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic show(input string tag, input int v, input logic [3:0] bl);
    int d;
    d = v;
    for (int p = 0; p < 4; p++) begin
      int n;
      n = 0;
      while (o_digitPosition != 2'(p) && n < 24) begin
        @(negedge clk);
        n++;
      end
      chk({tag, "_pos"}, 32'(o_digitPosition), p);
      chk({tag, "_bcd"}, 32'(o_bcd), d % 10);
      chk({tag, "_blank"}, 32'(o_blank), 32'(bl[p]));
      d = d / 10;
    end
  endtask
  task automatic do_load(input string tag, input int v);
    int n;
    @(negedge clk);
    value = 14'(v);
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (o_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy_fall"}, 32'(o_busy), 0);
  endtask
  initial begin
    #100000;
    $fatal(1, "FAIL global_timeout checks %0d", checks);
  end
  initial begin
    int bad;
    bit seen2;
    rst_n = 1'b0;
    load  = 1'b1;
    value = 14'd1234;
    repeat (3) @(negedge clk);
    chk("rst_pos", 32'(o_digitPosition), 0);
    chk("rst_bcd", 32'(o_bcd), 0);
    chk("rst_blank", 32'(o_blank), 0);
    chk("rst_busy", 32'(o_busy), 0);
    rst_n = 1'b1;
    load  = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      chk($sformatf("scan_pos_%0d", n), 32'(o_digitPosition), (n / 4) % 4);
    end
    @(negedge clk);
    value = 14'd1234;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("busy_hi_%0d", i), 32'(o_busy), 1);
      @(negedge clk);
    end
    chk("busy_lo_1234", 32'(o_busy), 0);
    show("v1234", 1234, 4'b0000);
    do_load("v7", 7);
    show("v7", 7, 4'b1110);
    do_load("v0", 0);
    show("v0", 0, 4'b1110);
    do_load("vsat", 16383);
    show("vsat", 9999, 4'b0000);
    @(negedge clk);
    value = 14'd4321;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    value = 14'd5678;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bad = 0;
    for (int i = 5; i < 15; i++) begin
      if (!o_busy) bad++;
      @(negedge clk);
    end
    chk("ign_busy_hold", bad, 0);
    chk("ign_busy_fall", 32'(o_busy), 0);
    show("ign", 4321, 4'b0000);
    do_load("v1111", 1111);
    value = 14'd2222;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("accept_at_fall", 32'(o_busy), 1);
    bad   = 0;
    seen2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_bcd != 4'd1 && o_bcd != 4'd2) bad++;
      if (seen2 && o_bcd == 4'd1) bad++;
      if (o_bcd == 4'd2) seen2 = 1'b1;
      @(negedge clk);
    end
    chk("tear_mix", bad, 0);
    chk("tear_seen_new", 32'(seen2), 1);
    show("v2222", 2222, 4'b0000);
    @(negedge clk);
    value = 14'd8888;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_busy_before", 32'(o_busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(o_busy), 0);
    chk("abort_pos", 32'(o_digitPosition), 0);
    chk("abort_bcd", 32'(o_bcd), 0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_bcd == 4'd8 || o_busy) bad++;
      @(negedge clk);
    end
    chk("abort_clean", bad, 0);
    show("abort", 0, 4'b1110);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
